// File: rtl/mem_lsu_pkg.sv
// Shared constants and types for the mem_lsu load/store initiator.
package mem_lsu_pkg;

  localparam int LANE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load formatter: picks the addressed byte/half/word out of a memory word and
// sign- or zero-extends it. Illegal funct3 codes fall through to a full word.
module mem_lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0]         byte_sh;
  logic [31:0]         half_sh;
  logic [LANE_W-1:0]   b;
  logic [2*LANE_W-1:0] h;

  assign byte_sh = rdata >> {a, 3'b000};
  assign half_sh = rdata >> {a[1], 4'b0000};
  assign b       = byte_sh[LANE_W-1:0];
  assign h       = half_sh[2*LANE_W-1:0];

  always_comb begin
    case (funct3)
      F3_B:    result = {{(32-LANE_W){b[LANE_W-1]}}, b};
      F3_BU:   result = {{(32-LANE_W){1'b0}}, b};
      F3_H:    result = {{(32-2*LANE_W){h[2*LANE_W-1]}}, h};
      F3_HU:   result = {{(32-2*LANE_W){1'b0}}, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for one port of the word RAM (IDLE/ACCESS/WAIT/RESP).
// Define MEM_LSU_FAULT_EN to report misaligned, illegal or out-of-range accesses.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int          RAM_DEPTH = 8192,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // rsp_valid is a single-cycle strobe that the core cannot stall.
  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] word_addr;
  logic [31:0] ld_result;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic        accept;
  logic        fault_q;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign word_addr = (addr_q - BASE_ADDR) >> 2;

`ifdef MEM_LSU_FAULT_EN
  logic        req_fault;
  logic [31:0] req_word;

  assign req_word = (req_addr - BASE_ADDR) >> 2;

  always_comb begin
    req_fault = (req_word >= 32'(RAM_DEPTH));
    if (req_we) begin
      case (req_funct3)
        F3_B:    ;
        F3_H:    if (req_addr[0]) req_fault = 1'b1;
        F3_W:    if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
        default: req_fault = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        F3_B, F3_BU: ;
        F3_H, F3_HU: if (req_addr[0]) req_fault = 1'b1;
        F3_W:        if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
        default:     req_fault = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fault_q <= 1'b0;
    else if (accept) fault_q <= req_fault;
  end
`else
  logic unused_cfg;
  assign fault_q    = 1'b0;
  assign unused_cfg = ^32'(RAM_DEPTH);
`endif

  // Half and word lanes ignore the low address bits, which aligns misaligned
  // accesses down when faults are not reported.
  always_comb begin
    case (f3_q)
      F3_B: begin
        st_we    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[LANE_W-1:0]}};
      end
      F3_H: begin
        st_we    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[2*LANE_W-1:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  mem_lsu_load_align load_align (
    .funct3 (f3_q),
    .a      (addr_q[1:0]),
    .rdata  (mem_rdata),
    .result (ld_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = (fault_q || we_q) ? ST_RESP : ST_WAIT;
      ST_WAIT:   state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      ST_IDLE:   req_ready = 1'b1;
      ST_ACCESS: begin
        if (!fault_q) begin
          mem_en   = 1'b1;
          mem_addr = word_addr;
          if (we_q) begin
            mem_we    = st_we;
            mem_wdata = st_wdata;
          end
        end
      end
      ST_RESP:   rsp_valid = 1'b1;
      default:   ;
    endcase
  end

  // rdata_q is cleared on acceptance so stores and faults respond with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= 32'h0;
    end else if (state == ST_WAIT) begin
      rdata_q <= ld_result;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_valid & fault_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: RAM emulator, byte-level reference memory, directed and random traffic.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:8191];
  logic [7:0]  ref_mem [0:32767];

  logic [31:0] last_rdata;
  logic [3:0]  last_we;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Word RAM emulator: byte-lane writes, registered read with 1-cycle latency.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr[12:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= ram[mem_addr[12:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010}) : !(f3 inside {3'b011, 3'b110, 3'b111});
`ifdef MEM_LSU_FAULT_EN
    return !legal || ((addr % acc_size(we, f3)) != 0) || ((addr / 4) >= 8192);
`else
    return legal && (addr == 32'hFFFF_FFFF) && !legal;
`endif
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    int          sz, en_cnt, rsp_cnt, en_cyc, rsp_cyc, lat, t;
    bit          flt, sgn;
    logic [31:0] start, lane_a, exp_rd, owd, oaddr, ord;
    logic [3:0]  ewe, owe;
    logic [31:0] ewd;
    logic        oerr;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    en_cnt = 0; rsp_cnt = 0; en_cyc = 0; rsp_cyc = 0;
    owe = 4'h0; oaddr = 32'h0; owd = 32'h0; ord = 32'h0; oerr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 1'b0);
      end
      if (mem_en) begin
        en_cnt++; en_cyc = k; owe = mem_we; oaddr = mem_addr; owd = mem_wdata;
      end
      if (rsp_valid) begin
        rsp_cnt++; rsp_cyc = k; ord = rsp_rdata; oerr = rsp_err;
      end
    end
    // Reference: byte-addressed view of the access.
    sz    = acc_size(we, f3);
    flt   = is_fault(we, f3, addr);
    sgn   = !we && !f3[2] && (sz < 4);
    start = addr - (addr % sz);
    ewe   = 4'h0;
    ewd   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      lane_a = (addr & ~32'h3) + i;
      if (lane_a >= start && lane_a < start + sz) ewe[i] = 1'b1;
      ewd[8*i +: 8] = 8'(wd >> (8 * (i % sz)));
    end
    exp_rd = 32'h0;
    if (!flt && we)
      for (int b = 0; b < sz; b++) ref_mem[15'(start + b)] = 8'(wd >> (8 * b));
    if (!flt && !we) begin
      for (int b = 0; b < sz; b++) exp_rd = exp_rd | (32'(ref_mem[15'(start + b)]) << (8 * b));
      if (sgn && sz == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (sgn && sz == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
    end
    lat = (flt || we) ? 2 : 3;
    chk("mem_en_count", 32'(en_cnt), flt ? 32'd0 : 32'd1);
    if (!flt) begin
      chk("mem_en_cycle", 32'(en_cyc), 32'd1);
      chk("mem_addr", oaddr, addr >> 2);
      chk("mem_we", {28'h0, owe}, we ? {28'h0, ewe} : 32'h0);
      if (we) chk("mem_wdata", owd, ewd);
    end
    chk("rsp_count", 32'(rsp_cnt), 32'd1);
    chk("rsp_latency", 32'(rsp_cyc), 32'(lat));
    chk("rsp_rdata", ord, exp_rd);
    chk("rsp_err", oerr, flt);
    last_rdata = ord; last_we = owe; last_wdata = owd;
  endtask

  initial begin
    int accepts, pulses, low_cnt, stray;
    int pc[3];
    for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h0;

    // Reset values while held in reset.
    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load a word.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    chk("sw_we_lit", {28'h0, last_we}, 32'hF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_lit", last_rdata, 32'hDEAD_BEEF);

    // Byte extension.
    do_req(1'b1, 3'b010, 32'h0, 32'h80FF_7F01);
    do_req(1'b0, 3'b000, 32'h2, 32'h0);
    chk("lb2_lit", last_rdata, 32'hFFFF_FFFF);
    do_req(1'b0, 3'b100, 32'h2, 32'h0);
    chk("lbu2_lit", last_rdata, 32'h0000_00FF);
    do_req(1'b0, 3'b000, 32'h3, 32'h0);
    chk("lb3_lit", last_rdata, 32'hFFFF_FF80);

    // Halfword store into the upper half.
    do_req(1'b1, 3'b001, 32'h6, 32'h1234_ABCD);
    chk("sh_we_lit", {28'h0, last_we}, 32'hC);
    chk("sh_wdata_lit", last_wdata, 32'hABCD_ABCD);
    do_req(1'b0, 3'b101, 32'h6, 32'h0);
    chk("lhu_lit", last_rdata, 32'h0000_ABCD);
    do_req(1'b0, 3'b001, 32'h6, 32'h0);
    chk("lh_lit", last_rdata, 32'hFFFF_ABCD);

    // Back-to-back loads with req_valid held.
    accepts = 0; pulses = 0; low_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (pulses < 3) pc[pulses] = k;
        pulses++;
        chk("b2b_rdata", rsp_rdata, 32'hDEAD_BEEF);
      end
      if (!req_ready) low_cnt++;
      if (accepts < 3) begin
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        if (req_ready) accepts++;
      end else begin
        req_valid = 1'b0;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_ready_low", 32'(low_cnt), 32'd9);
    chk("b2b_first", 32'(pc[0]), 32'd3);
    chk("b2b_gap1", 32'(pc[1] - pc[0]), 32'd4);
    chk("b2b_gap2", 32'(pc[2] - pc[1]), 32'd4);

    // Reset during ACCESS (stage 1) and during WAIT (stage 2).
    for (int stage = 1; stage <= 2; stage++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk);
      for (int k = 1; k <= stage; k++) @(negedge clk);
      req_valid = 1'b0;
      if (stage == 1) chk("pre_rst_mem_en", mem_en, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_mem_en", mem_en, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_req_ready", req_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (rsp_valid || mem_en) stray++;
      end
      chk("post_rst_stray", 32'(stray), 32'd0);
      chk("post_rst_ready", req_ready, 1'b1);
    end

    // Misaligned word, illegal store funct3, out-of-range word address.
    do_req(1'b0, 3'b010, 32'h5, 32'h0);
`ifdef MEM_LSU_FAULT_EN
    chk("lw5_fault_rdata", last_rdata, 32'h0);
`else
    chk("lw5_aligned_rdata", last_rdata, 32'hABCD_0000);
`endif
    do_req(1'b1, 3'b100, 32'h20, 32'h5555_AAAA);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    do_req(1'b0, 3'b010, 32'h8000, 32'h0);

    // Randomized mix against the byte-level reference.
    for (int n = 0; n < 80; n++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 63)), $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
